// File: rtl/br_result_update_queue_pkg.sv
// rtl/br_result_update_queue_pkg.sv - shared branch-result types and queue constants
//
// Types shared between the branch-result update queue and the branch
// predictor. BranchResult is the payload carried from the execution lanes
// to the PHT/history update port.
package br_result_update_queue_pkg;

  localparam int INT_ISSUE_WIDTH     = 2;
  localparam int BR_UPD_QUEUE_DEPTH  = 8;
  localparam int ADDR_WIDTH          = 32;
  localparam int INSN_ADDR_BIT_WIDTH = 2;
  localparam int GAS_OFFSET          = 0;
  localparam int PHT_PAP_BITS        = 8;
  localparam int PHT_IDX_LSB         = INSN_ADDR_BIT_WIDTH + GAS_OFFSET;

  typedef logic [1:0] PhtEntry;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] brAddr;
    logic                  execTaken;
    logic                  mispred;
    logic                  isCondBr;
    PhtEntry               phtPrevValue;
  } BranchResult;

  // Pointer into a default-depth update queue.
  typedef logic [$clog2(BR_UPD_QUEUE_DEPTH)-1:0] BrUpdQueueIndexPath;

endpackage

// File: rtl/br_result_update_queue_if.sv
// rtl/br_result_update_queue_if.sv - producer/predictor-side bus of the branch update queue
//
// Signals:
//   inValid/inResult : resolved branches from the integer lanes
//   full             : fewer than LANES free entries, producer must stall
//   hold             : predictor busy, suppresses all update output
//   outValid/outResult : PHT/history update lanes
//   overflow         : sticky, a valid input was dropped
//   count            : queue occupancy
// Modports: slave (the queue), master (producer + predictor side).
interface br_result_update_queue_if
  import br_result_update_queue_pkg::*;
#(
  parameter int LANES = INT_ISSUE_WIDTH,
  parameter int DEPTH = BR_UPD_QUEUE_DEPTH
) ();

  logic [LANES-1:0]       inValid;
  BranchResult            inResult [LANES];
  logic                   full;
  logic                   hold;
  logic [LANES-1:0]       outValid;
  BranchResult            outResult [LANES];
  logic                   overflow;
  logic [$clog2(DEPTH):0] count;

  modport slave (
    input  inValid, inResult, hold,
    output full, outValid, outResult, overflow, count
  );

  modport master (
    output inValid, inResult, hold,
    input  full, outValid, outResult, overflow, count
  );

endinterface

// File: rtl/br_result_update_queue_storage.sv
// rtl/br_result_update_queue_storage.sv - multi-port circular register file with pointers and count
//
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   wr_data_i    : LANES compacted write slots, slot k lands at wr_ptr+k
//   n_enq_i      : number of write slots used this cycle
//   n_deq_i      : number of entries retired from the head this cycle
//   rd_data_o    : entries at rd_ptr+k, k = 0..LANES-1
//   count_o      : registered occupancy
module br_result_update_queue_storage
  import br_result_update_queue_pkg::*;
#(
  parameter int LANES = INT_ISSUE_WIDTH,
  parameter int DEPTH = BR_UPD_QUEUE_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  BranchResult       wr_data_i [LANES],
  input  logic [CNT_W-1:0]  n_enq_i,
  input  logic [CNT_W-1:0]  n_deq_i,
  output BranchResult       rd_data_o [LANES],
  output logic [CNT_W-1:0]  count_o
);

  BranchResult      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Payload storage carries no reset; only pointers define which slots are live.
  always_ff @(posedge clk) begin
    for (int k = 0; k < LANES; k++) begin
      if (CNT_W'(k) < n_enq_i) begin
        mem_q[wr_ptr_q + PTR_W'(k)] <= wr_data_i[k];
      end
    end
  end

  always_comb begin
    // n_enq/n_deq never exceed LANES <= DEPTH/2, so the low bits are exact.
    wr_ptr_d = wr_ptr_q + n_enq_i[PTR_W-1:0];
    rd_ptr_d = rd_ptr_q + n_deq_i[PTR_W-1:0];
    count_d  = count_q + n_enq_i - n_deq_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      rd_data_o[k] = mem_q[rd_ptr_q + PTR_W'(k)];
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/br_result_update_queue.sv
// rtl/br_result_update_queue.sv - in-order branch-result queue feeding the PHT update port
//
// Buffers resolved branches and replays them in order, never issuing two
// update lanes in one cycle that hit the same PHT index.
// Optional feature macro: BR_UPDATE_BYPASS_EN (zero-latency path when empty).
//
// Ports:
//   clk  : clock
//   rst  : asynchronous active-low reset
//   bus  : br_result_update_queue_if.slave (inputs, full, hold, outputs,
//          overflow, count)
module br_result_update_queue
  import br_result_update_queue_pkg::*;
#(
  parameter int LANES    = INT_ISSUE_WIDTH,
  parameter int DEPTH    = BR_UPD_QUEUE_DEPTH,
  parameter int IDX_BITS = PHT_PAP_BITS,
  parameter int IDX_LSB  = PHT_IDX_LSB,
  localparam int CNT_W   = $clog2(DEPTH) + 1
) (
  input logic                    clk,
  input logic                    rst,
  br_result_update_queue_if.slave bus
);

  BranchResult      cmp     [LANES];
  BranchResult      src     [LANES];
  BranchResult      wr_data [LANES];
  BranchResult      rd_data [LANES];
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] n_in, n_acc, n_out, n_deq, n_byp, n_enq, avail;
  logic             full, accept, byp, go, conflict;
  logic             overflow_q, overflow_d;

  br_result_update_queue_storage #(
    .LANES (LANES),
    .DEPTH (DEPTH)
  ) u_storage (
    .clk       (clk),
    .rst       (rst),
    .wr_data_i (wr_data),
    .n_enq_i   (n_enq),
    .n_deq_i   (n_deq),
    .rd_data_o (rd_data),
    .count_o   (count_q)
  );

  assign full   = count_q > CNT_W'(DEPTH - LANES);
  assign accept = !full;

  // Compact valid input lanes so that slot 0 holds the lowest valid lane.
  always_comb begin
    n_in = '0;
    for (int k = 0; k < LANES; k++) cmp[k] = '0;
    for (int i = 0; i < LANES; i++) begin
      if (bus.inValid[i]) begin
        for (int k = 0; k < LANES; k++) begin
          if (CNT_W'(k) == n_in) cmp[k] = bus.inResult[i];
        end
        n_in = n_in + CNT_W'(1);
      end
    end
    n_acc = accept ? n_in : '0;
  end

`ifdef BR_UPDATE_BYPASS_EN
  assign byp = (count_q == '0) && !bus.hold;
`else
  assign byp = 1'b0;
`endif

  // Output selection: candidates come from the queue head or, when bypassing,
  // straight from the compacted inputs. A lane issues only if every earlier
  // lane issued and its PHT index differs from all of them; the first
  // blocked lane stops the scan so order is preserved.
  always_comb begin
    avail = byp ? n_acc : count_q;
    go    = !bus.hold;
    n_out = '0;
    for (int k = 0; k < LANES; k++) begin
      src[k]           = byp ? cmp[k] : rd_data[k];
      bus.outResult[k] = src[k];
      bus.outValid[k]  = 1'b0;
    end
    for (int k = 0; k < LANES; k++) begin
      conflict = 1'b0;
      for (int j = 0; j < k; j++) begin
        if (src[j].brAddr[IDX_LSB +: IDX_BITS] == src[k].brAddr[IDX_LSB +: IDX_BITS]) begin
          conflict = 1'b1;
        end
      end
      if (go && (CNT_W'(k) < avail) && !conflict) begin
        bus.outValid[k] = 1'b1;
        n_out           = CNT_W'(k + 1);
      end else begin
        go = 1'b0;
      end
    end
  end

  // Bypassed inputs skip storage; the remainder (e.g. a conflicted lane 1)
  // is written starting at slot 0.
  always_comb begin
    n_deq = byp ? '0 : n_out;
    n_byp = byp ? n_out : '0;
    n_enq = n_acc - n_byp;
    for (int k = 0; k < LANES; k++) begin
      wr_data[k] = '0;
      for (int j = 0; j < LANES; j++) begin
        if (CNT_W'(j) == CNT_W'(k) + n_byp) wr_data[k] = cmp[j];
      end
    end
  end

  assign overflow_d = overflow_q | (full & (|bus.inValid));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign bus.full     = full;
  assign bus.overflow = overflow_q;
  assign bus.count    = count_q;

endmodule

// File: doc/br_result_update_queue.md
# br_result_update_queue

Buffers resolved branch results from the integer execution lanes and replays them, in program-resolution order, to the branch predictor's PHT/history update port. The queue guarantees that no two update lanes issued in the same cycle target the same PHT index, so the predictor's multi-bank write ports never see a same-bank write conflict. It sits between the integer pipelines' branch-resolution output and the predictor's `brResult` input.

## Interface
Parameters:
- `LANES`, `INT_ISSUE_WIDTH` (2): input and output lanes per cycle.
- `DEPTH`, 8: queue entries; power of two, ≥ 2·`LANES`.
- `IDX_BITS`, `PHT_PAP_BITS`: PHT index width.
- `IDX_LSB`, `INSN_ADDR_BIT_WIDTH + GAS_OFFSET`: LSB of the PHT index within `brAddr`.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset; asynchronous, active-low.
- `inValid[LANES]` in 1: lane carries a resolved branch.
- `inResult[LANES]` in `$bits(BranchResult)`: brAddr, execTaken, mispred, isCondBr, phtPrevValue.
- `full` out 1: fewer than `LANES` free entries; producer stalls.
- `hold` in 1: predictor busy (e.g. reset sweep); suppresses all output.
- `outValid[LANES]` out 1: update lane valid this cycle.
- `outResult[LANES]` out `$bits(BranchResult)`: update payload.
- `overflow` out 1: sticky; a valid input was dropped.
- `count` out `$clog2(DEPTH)+1`: current occupancy.

## Operation
- Enqueue: valid lanes are compacted in lane order (lane 0 first) and written at `wrPtr`. Invalid lanes occupy no slot.
- Input presented while `full`=1 is dropped and sets `overflow`. `overflow` clears only on reset.
- Index: `idx(e) = e.brAddr[IDX_LSB+IDX_BITS-1 : IDX_LSB]`.
- Dequeue, when `hold`=0:
  - Head entry → out lane 0 whenever `count` ≥ 1.
  - Head+1 → out lane 1 only if `count` ≥ 2 and `idx(head+1) != idx(head)`.
  - An index conflict defers head+1 to the next cycle, where it becomes lane 0.
- `hold`=1: `outValid` is all 0 and nothing is dequeued.
- Pointers wrap modulo `DEPTH`.
- Simultaneous enqueue and dequeue: `count_next = count + nEnq - nDeq`. `full` uses the registered `count`, not `count_next`.
- A mispredicted result is queued in order like any other entry; there is no reordering.

## Timing
- Reset values: `count`=0, `wrPtr`=`rdPtr`=0, `outValid`=0, `full`=0, `overflow`=0. Queue contents are don't-care.
- Reset asserted mid-operation empties the queue immediately (asynchronous). Pending entries are lost, without `overflow`.
- Latency: input at cycle N → visible on `outValid` at N+1 (queue empty, `hold`=0).
- Outputs are combinational from the queue registers and `hold`. The predictor samples them every cycle; there is no ready handshake.
- `full` = (`count` > `DEPTH`−`LANES`), registered-count based.

## Configuration
- `BR_UPDATE_BYPASS_EN` defined:
  - When `count`=0 and `hold`=0, valid inputs go to outputs in the same cycle (zero latency), with the same index-conflict rule.
  - Bypassed entries are not written to the queue.
  - A lane-1 input deferred by a conflict is enqueued normally.
- `BR_UPDATE_BYPASS_EN` undefined: always one-cycle latency through the queue.

## Structure
- Shared package (`FetchUnitTypes`):
  - `BranchResult` struct, already shared with the predictor.
  - `BrUpdQueueIndexPath` typedef.
  - `BR_UPD_QUEUE_DEPTH` constant.
- Sub-module `BrUpdQueueStorage`: a `DEPTH`-entry register file with `LANES` write and `LANES` read ports, plus pointer/count logic.
- The conflict check, compaction and bypass logic live in the top module.

## Test plan
- Reset, then single result (brAddr=0x1000, taken) on lane 0 at cycle 1 → `outValid[0]`=1 at cycle 2 with the same payload; `count` returns to 0.
- Two results, brAddr 0x1000 and 0x1004, with distinct indices → both output in the same cycle on lanes 0 and 1.
- Two results with the same index (0x1000 and 0x1000+4·2^`IDX_BITS`) → lane 0 in cycle N+1, the second on lane 0 in cycle N+2; never both in one cycle.
- `hold`=1 while 8 results arrive → `full`=1 at `count`=7; a further valid input sets `overflow`=1. Release `hold` → entries drain in order, 2 per cycle with no conflicts, `count` reaching 0 after 4 cycles.
- Reset asserted with `count`=5 → `count`=0 and `outValid`=0 immediately, without waiting for a clock.
- With `BR_UPDATE_BYPASS_EN`: empty queue, lane-0 input → `outValid[0]`=1 in the same cycle and `count` stays 0.
